// File: rtl/haar_window_scanner_pkg.sv
// Shared types and helpers for the Haar window scanner.
package haar_window_scanner_pkg;

    // Scanner FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_e;

    localparam int unsigned COORD_W_DEF = 9;
    localparam int unsigned CNT_W       = 16;

    // Saturating increment for the detection counter
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/haar_window_scanner_det_fifo.sv
// Show-ahead synchronous FIFO holding detection records.
module haar_det_fifo #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Occupancy flags; the extra pointer bit separates full from empty
    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
        dout     = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Pointer registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/haar_window_scanner.sv
// Raster-scans a detection window over the frame, hands each window to the
// cascade and queues the coordinates of passing windows.
module haar_window_scanner
    import haar_window_scanner_pkg::*;
#(
    parameter int unsigned IMG_W      = 320,
    parameter int unsigned IMG_H      = 240,
    parameter int unsigned WIN        = 24,
    parameter int unsigned STEP       = 1,
    parameter int unsigned COORD_W    = COORD_W_DEF,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               win_valid,
    output logic [COORD_W-1:0] win_x,
    output logic [COORD_W-1:0] win_y,
    input  logic               cascade_done,
    input  logic               cascade_pass,
    output logic               det_valid,
    input  logic               det_ready,
    output logic [COORD_W-1:0] det_x,
    output logic [COORD_W-1:0] det_y,
    output logic [CNT_W-1:0]   det_count,
    output logic               overflow
);

    localparam int unsigned CW1 = COORD_W + 1;
    localparam logic [CW1-1:0] X_LIM  = CW1'(IMG_W - WIN);
    localparam logic [CW1-1:0] Y_LIM  = CW1'(IMG_H - WIN);
    localparam logic [CW1-1:0] STEP_C = CW1'(STEP);

    scan_state_e          state_q, state_d;
    logic [COORD_W-1:0]   win_x_q, win_x_d, win_y_q, win_y_d;
    logic                 win_valid_q, win_valid_d;
    logic                 busy_q, busy_d, done_q, done_d;
    logic [CNT_W-1:0]     det_count_q, det_count_d;
    logic                 overflow_q, overflow_d;
    logic [CW1-1:0]       x_next, y_next;
    logic                 x_last, y_last;
    logic                 push_c, pop_c, fifo_full, fifo_empty;
    logic [2*COORD_W-1:0] fifo_dout;

    // Next-state, coordinate advance and detection bookkeeping
    always_comb begin
        state_d     = state_q;
        win_x_d     = win_x_q;
        win_y_d     = win_y_q;
        det_count_d = det_count_q;
        overflow_d  = overflow_q;
        push_c      = 1'b0;
        pop_c       = det_ready && !fifo_empty;
        x_next      = {1'b0, win_x_q} + STEP_C;
        y_next      = {1'b0, win_y_q} + STEP_C;
        x_last      = (x_next > X_LIM);
        y_last      = (y_next > Y_LIM);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_ISSUE;
                    win_x_d     = '0;
                    win_y_d     = '0;
                    det_count_d = '0;
                    overflow_d  = 1'b0;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (cascade_done) begin
                    push_c = cascade_pass;
                    if (x_last && y_last) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                        if (x_last) begin
                            win_x_d = '0;
                            win_y_d = COORD_W'(y_next);
                        end else begin
                            win_x_d = COORD_W'(x_next);
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (push_c) begin
            if (fifo_full && !pop_c) begin
                overflow_d = 1'b1;
            end else begin
                det_count_d = sat_inc(det_count_q);
            end
        end

        win_valid_d = (state_d == ST_ISSUE);
        busy_d      = (state_d == ST_ISSUE) || (state_d == ST_WAIT);
        done_d      = (state_d == ST_DONE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            win_x_q     <= '0;
            win_y_q     <= '0;
            win_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            det_count_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_x_q     <= win_x_d;
            win_y_q     <= win_y_d;
            win_valid_q <= win_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            det_count_q <= det_count_d;
            overflow_q  <= overflow_d;
        end
    end

    haar_det_fifo #(
        .WIDTH (2 * COORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_c),
        .pop     (pop_c),
        .din     ({win_y_q, win_x_q}),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign win_valid = win_valid_q;
    assign win_x     = win_x_q;
    assign win_y     = win_y_q;
    assign det_count = det_count_q;
    assign overflow  = overflow_q;
    assign det_valid = !fifo_empty;
    assign det_x     = fifo_dout[COORD_W-1:0];
    assign det_y     = fifo_dout[2*COORD_W-1:COORD_W];

endmodule
